clock_divider_bank: RTL and testbench
=====================================

# clock_divider_bank

Parametrised multi-channel clock/tick generator driven from the board clock `SystemClk`. It produces, per channel, a single-cycle `tick` strobe and a 50%-duty divided `clk_out`. Each channel has a run-time reloadable divisor, an enable, and a common resynchronise input. It replaces the fixed two-output divider that feeds the pipeline clock and the UART baud clock. Default configuration reproduces that pair: channel 0 half-period 2, channel 1 half-period 326.

## Interface
Parameters:
- `CHANNELS`, 2: number of independent divider channels (1..16).
- `CNT_W`, 16: divisor and counter width.
- `DEFAULT_DIVS`, {16'd326, 16'd2}: packed `CHANNELS*CNT_W` reset divisors; channel i uses bits `[i*CNT_W +: CNT_W]`.

Ports:
- `SystemClk`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  CHANNELS  per-channel run enable.
- `resync`  in  1  single-cycle pulse that restarts all channels in phase.
- `load`  in  1  divisor write strobe.
- `load_ch`  in  clog2(CHANNELS) (min 1)  target channel for `load`.
- `load_div`  in  CNT_W  new half-period in SystemClk cycles.
- `tick`  out  CHANNELS  one-cycle strobe at each terminal count.
- `clk_out`  out  CHANNELS  divided clock; toggles at each terminal count.

## Operation
- Per-channel registers: `cnt`, `div_act` (active divisor), `div_shadow`, `tick`, `clk_out`.
- Reset: `cnt`=1, `div_act`=`div_shadow`=DEFAULT_DIVS slice, `tick`=0, `clk_out`=0.
- Terminal condition: `enable[i]` && `div_act`!=0 && `cnt`==`div_act`.
- At terminal: `cnt`<=1, `clk_out`<=~`clk_out`, `tick`<=1, `div_act`<=`div_shadow` (value held before this edge).
- Enabled, not terminal: `cnt`<=`cnt`+1, `tick`<=0.
- `enable[i]`=0: `cnt` and `clk_out` hold; `tick`<=0. If `div_shadow`!=`div_act`, apply it and set `cnt`<=1.
- `div_act`==0: channel halted. `tick`=0, `clk_out` holds, `cnt` held at 1, and `div_shadow` is copied to `div_act` every cycle.
- `load`: `div_shadow[load_ch]`<=`load_div`. A load with `load_ch`>=CHANNELS is ignored. The new divisor is applied only at a terminal event, or immediately when the channel is disabled/halted. This guarantees a glitch-free period change.
- Load and terminal on the same edge: the terminal applies the old shadow, and the new value lands in the shadow for the next terminal.
- `resync`: for all channels `cnt`<=1, `clk_out`<=0, `tick`<=0, `div_act`<=`div_shadow`. A `load` on the same edge still writes the shadow but is not applied.
- Priority: `reset` > `resync` > terminal/count. `reset` mid-period discards any pending shadow value.
- Width: `cnt` never exceeds `div_act`. No wrap-around is possible. Maximum half-period is 2^CNT_W−1.

## Timing
- Divisor D≥1: `tick` goes high after the D-th rising edge following reset deassertion (or `resync`), for one cycle, then repeats every D cycles.
- `clk_out` period is 2·D cycles at 50% duty. D=1 gives SystemClk/2 and `tick` constantly high.
- All outputs are registered. No combinational path from any input to any output.
- Enable rise: counting resumes on the same edge. Enable fall: that edge performs no terminal, and `tick` is 0 in the following cycle.

## Structure
- Shared package `clock_pkg`:
  - `CNT_W` default;
  - default divisor constants `DIV_PIPE=2` and `DIV_BAUD=326`;
  - a function packing default divisors.
- Sub-module `clock_div_channel`:
  - one channel holding `cnt`, `div_act`, `div_shadow`, `tick`, `clk_out`;
  - instantiated CHANNELS times in a generate loop;
  - top level only decodes `load_ch` into per-channel load strobes and fans out `resync`.

## Test plan
- Reset defaults, all enabled: channel 0 `clk_out` toggles every 2 cycles, `tick` at edges 2,4,6…. Channel 1 first `tick` at edge 326, period 652 cycles.
- `load` ch0=5 while enabled, mid-period: the current period completes with D=2. The next period is 5 cycles, with no short pulse on `clk_out`.
- Disable ch1 at edge 100, hold 50 cycles, re-enable: `tick`/`clk_out` are frozen during disable. The first `tick` comes 226 enabled cycles after re-enable.
- `load` ch0=0: after the next terminal the channel halts (`tick`=0, `clk_out` static). `load` ch0=3 then restarts it, with the first `tick` 3 cycles later.
- `resync` pulse with channels at arbitrary phase: next edge all `clk_out`=0 and `cnt`=1. Channels then tick in phase at D0, D1 edges later.
- `reset` asserted mid-count after a pending shadow load: all outputs 0, divisors revert to 2/326. `load` with `load_ch`=CHANNELS has no effect.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the multi-channel clock divider bank.
// Default divisors reproduce the legacy pipeline/baud divider pair.
package clock_pkg;

  localparam int DEFAULT_CNT_W = 16;

  localparam logic [DEFAULT_CNT_W-1:0] DIV_PIPE = 16'd2;
  localparam logic [DEFAULT_CNT_W-1:0] DIV_BAUD = 16'd326;

  // Channel 0 sits in the low slice, matching the [i*CNT_W +: CNT_W] layout.
  function automatic logic [2*DEFAULT_CNT_W-1:0] pack_divs(
    input logic [DEFAULT_CNT_W-1:0] div0,
    input logic [DEFAULT_CNT_W-1:0] div1
  );
    return {div1, div0};
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: half-period counter with a shadowed divisor that is
// only applied at a terminal count, while disabled/halted, or on resync.
module clock_div_channel
  import clock_pkg::*;
#(
  parameter int               CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(1)
) (
  input  logic             SystemClk,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_act_reg;
  logic [CNT_W-1:0] div_shadow_reg;
  logic             tick_reg;
  logic             clk_out_reg;

  always_ff @(posedge SystemClk) begin
    if (reset) begin
      cnt_reg        <= CNT_W'(1);
      div_act_reg    <= DEFAULT_DIV;
      div_shadow_reg <= DEFAULT_DIV;
      tick_reg       <= 1'b0;
      clk_out_reg    <= 1'b0;
    end else begin
      // The shadow always takes a write; only the branches below move it
      // into the active divisor, using the value held before this edge.
      if (load)
        div_shadow_reg <= load_div;

      if (resync) begin
        cnt_reg     <= CNT_W'(1);
        clk_out_reg <= 1'b0;
        tick_reg    <= 1'b0;
        div_act_reg <= div_shadow_reg;
      end else if (div_act_reg == '0) begin
        // Halted: park the counter and keep polling the shadow for a restart.
        cnt_reg     <= CNT_W'(1);
        tick_reg    <= 1'b0;
        div_act_reg <= div_shadow_reg;
      end else if (!enable) begin
        tick_reg <= 1'b0;
        if (div_shadow_reg != div_act_reg) begin
          div_act_reg <= div_shadow_reg;
          cnt_reg     <= CNT_W'(1);
        end
      end else if (cnt_reg == div_act_reg) begin
        cnt_reg     <= CNT_W'(1);
        clk_out_reg <= ~clk_out_reg;
        tick_reg    <= 1'b1;
        div_act_reg <= div_shadow_reg;
      end else begin
        cnt_reg  <= cnt_reg + CNT_W'(1);
        tick_reg <= 1'b0;
      end
    end
  end

  assign tick    = tick_reg;
  assign clk_out = clk_out_reg;

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel tick / divided-clock generator. Decodes the divisor write
// target and fans the shared controls out to one channel per output bit.
module clock_divider_bank
  import clock_pkg::*;
#(
  parameter int                          CHANNELS     = 2,
  parameter int                          CNT_W        = DEFAULT_CNT_W,
  parameter logic [CHANNELS*CNT_W-1:0]   DEFAULT_DIVS =
    (CHANNELS*CNT_W)'(pack_divs(DIV_PIPE, DIV_BAUD))
) (
  input  logic                           SystemClk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            enable,
  input  logic                           resync,
  input  logic                           load,
  input  logic [sel_width(CHANNELS)-1:0] load_ch,
  input  logic [CNT_W-1:0]               load_div,
  output logic [CHANNELS-1:0]            tick,
  output logic [CHANNELS-1:0]            clk_out
);

  localparam int SEL_W = sel_width(CHANNELS);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      // A load_ch value at or beyond CHANNELS matches no channel and is dropped.
      logic ch_load;
      assign ch_load = load && (load_ch == SEL_W'(gi));

      clock_div_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIVS[gi*CNT_W +: CNT_W])
      ) u_ch (
        .SystemClk (SystemClk),
        .reset     (reset),
        .enable    (enable[gi]),
        .resync    (resync),
        .load      (ch_load),
        .load_div  (load_div),
        .tick      (tick[gi]),
        .clk_out   (clk_out[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank (3 channels: divisors 2, 326, 3).
// Outputs are sampled 1 time unit after each rising edge.
module tb_clock_divider_bank;

  localparam int CH = 3;
  localparam int CW = 16;

  logic          SystemClk = 1'b0;
  logic          reset;
  logic [CH-1:0] enable;
  logic          resync;
  logic          load;
  logic [1:0]    load_ch;
  logic [CW-1:0] load_div;
  logic [CH-1:0] tick;
  logic [CH-1:0] clk_out;

  int            compared   = 0;
  int            mismatched = 0;
  logic [CH-1:0] exp_clk;
  logic [CH-1:0] et;

  always #5 SystemClk = ~SystemClk;

  clock_divider_bank #(
    .CHANNELS     (CH),
    .CNT_W        (CW),
    .DEFAULT_DIVS ({16'd3, 16'd326, 16'd2})
  ) dut (
    .SystemClk (SystemClk),
    .reset     (reset),
    .enable    (enable),
    .resync    (resync),
    .load      (load),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  task automatic chk(input string tag, input int e, input logic [CH-1:0] obs,
                     input logic [CH-1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  // Advance one edge; expected clk_out toggles wherever a tick is expected.
  task automatic step(input int e, input logic [CH-1:0] exp_tick);
    @(posedge SystemClk);
    #1;
    exp_clk = exp_clk ^ exp_tick;
    chk("tick", e, tick, exp_tick);
    chk("clk_out", e, clk_out, exp_clk);
  endtask

  task automatic hard_reset();
    reset    = 1'b1;
    enable   = '0;
    resync   = 1'b0;
    load     = 1'b0;
    load_ch  = '0;
    load_div = '0;
    @(posedge SystemClk);
    #1;
    exp_clk = '0;
    chk("reset_tick", 0, tick, '0);
    chk("reset_clk_out", 0, clk_out, '0);
    reset = 1'b0;
  endtask

  initial begin
    // A: reset defaults, ch0 D=2 and ch1 D=326 free running
    hard_reset();
    enable = 3'b011;
    for (int e = 1; e <= 660; e++) begin
      et = {1'b0, (e % 326 == 0), (e % 2 == 0)};
      step(e, et);
    end
    $display("step A: default divisors, %0d compared so far", compared);

    // B: ch0 load 5 mid-period, then load 3 on a terminal edge
    hard_reset();
    enable = 3'b011;
    for (int e = 1; e <= 20; e++) begin
      load     = (e == 1) || (e == 7);
      load_ch  = 2'd0;
      load_div = (e == 1) ? 16'd5 : 16'd3;
      et = {2'b00, (e inside {2, 7, 12, 15, 18})};
      step(e, et);
    end
    load = 1'b0;
    $display("step B: glitch-free reload, %0d compared so far", compared);

    // C: ch1 disabled for edges 101..150, ch0 disabled for 102..150
    hard_reset();
    for (int e = 1; e <= 400; e++) begin
      enable[0] = !(e >= 102 && e <= 150);
      enable[1] = !(e >= 101 && e <= 150);
      enable[2] = 1'b0;
      et = {1'b0, (e == 376),
            ((e <= 100 && e % 2 == 0) || (e >= 151 && e % 2 == 1))};
      step(e, et);
    end
    $display("step C: enable hold, %0d compared so far", compared);

    // D: ch0 halted by divisor 0, restarted by divisor 3
    hard_reset();
    enable = 3'b011;
    for (int e = 1; e <= 18; e++) begin
      load     = (e == 1) || (e == 6);
      load_ch  = 2'd0;
      load_div = (e == 1) ? 16'd0 : 16'd3;
      et = {2'b00, (e inside {2, 10, 13, 16})};
      step(e, et);
    end
    load = 1'b0;
    $display("step D: halt and restart, %0d compared so far", compared);

    // E: pending ch1=7, then resync at edge 12 together with a ch0 load of 3
    hard_reset();
    enable = 3'b011;
    for (int e = 1; e <= 30; e++) begin
      load     = (e == 5) || (e == 12);
      load_ch  = (e == 5) ? 2'd1 : 2'd0;
      load_div = (e == 5) ? 16'd7 : 16'd3;
      resync   = (e == 12);
      if (e == 12) begin
        exp_clk = '0;
        et = '0;
      end else begin
        et = {1'b0, (e inside {19, 26}),
              ((e < 12 && e % 2 == 0) || (e inside {14, 17, 20, 23, 26, 29}))};
      end
      step(e, et);
    end
    load   = 1'b0;
    resync = 1'b0;
    $display("step E: resync, %0d compared so far", compared);

    // F: reset discards a pending shadow; load_ch == CHANNELS is ignored
    hard_reset();
    enable = 3'b011;
    for (int e = 1; e <= 4; e++) begin
      load     = (e == 3);
      load_ch  = 2'd0;
      load_div = 16'd5;
      reset    = (e == 4);
      if (e == 4) begin
        exp_clk = '0;
        et = '0;
      end else begin
        et = {2'b00, (e == 2)};
      end
      step(e, et);
    end
    reset  = 1'b0;
    load   = 1'b0;
    enable = 3'b111;
    for (int e = 1; e <= 12; e++) begin
      load     = (e == 1);
      load_ch  = 2'd3;
      load_div = 16'd9;
      et = {(e % 3 == 0), 1'b0, (e % 2 == 0)};
      step(e, et);
    end
    load = 1'b0;
    $display("step F: reset revert and out-of-range load, %0d compared so far", compared);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
